rv32i_inst_encoder: RTL and testbench
=====================================

Name: rv32i_inst_encoder

Overview:
- Encoder counterpart of the control decoder: accepts field-level instruction commands (class, rd, rs1, rs2, funct3, imm) over a valid/ready handshake.
- Packs each legal command into a 32-bit RV32I word and streams it as sequential writes into instruction memory.
- Used by self-checking benches and the boot loader to build programs in IMEM.
- Illegal or unencodable commands are consumed, flagged and dropped.

Parameters:
ADDR_W, 32, width of instruction memory byte address
BASE_ADDR, 32'h0000_0000, first write address after reset or restart

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_restart  in  1  synchronous; reload write address to BASE_ADDR, clear o_count
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&&ready
i_cmd_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9-15 illegal
i_rd  in  5  destination register
i_rs1  in  5  source register 1
i_rs2  in  5  source register 2
i_funct3  in  3  funct3 field
i_funct7_b5  in  1  funct7[5] (SUB/SRA/SRAI)
i_imm  in  32  byte-level immediate, sign-extended value
o_wr_valid  out  1  IMEM write request
i_wr_ready  in  1  IMEM accepts write
o_wr_addr  out  ADDR_W  byte address, word aligned
o_wr_data  out  32  encoded instruction
o_illegal  out  1  one-cycle pulse when an illegal command is consumed
o_err  out  1  sticky illegal flag, cleared by reset or restart
o_count  out  16  instructions written since reset/restart, saturates at 16'hFFFF

Behaviour:
- Reset values: o_wr_valid=0, o_wr_addr=BASE_ADDR, o_wr_data=0, o_illegal=0, o_err=0, o_count=0.
- Output stage is a single register.
  - o_cmd_ready = !o_wr_valid || i_wr_ready (combinational).
  - Latency: command accepted at edge N drives o_wr_valid/o_wr_data from edge N onward.
- While o_wr_valid=1 && i_wr_ready=0, o_wr_addr and o_wr_data hold stable.
- Write completes when o_wr_valid && i_wr_ready.
  - o_wr_addr += 4, wrapping modulo 2^ADDR_W.
  - o_count += 1, saturating.
  - o_wr_valid drops unless a new legal command is accepted in the same cycle (back-to-back, one word per cycle).
- Encoding:
  - opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - U-type: imm[31:12].
  - I-type: imm[11:0].
  - S-type: imm[11:5] | imm[4:0].
  - B-type: imm[12|10:5] | imm[4:1|11].
  - J-type: imm[20|10:1|11|19:12].
  - OP funct7 = {0, i_funct7_b5, 00000}.
  - Unused fields are zero.
- Legality checks; any failure makes the command illegal:
  - U: imm[11:0]=0.
  - I/S: imm fits signed 12 bits.
  - B: imm fits signed 13 bits and imm[0]=0.
  - J: imm fits signed 21 bits and imm[0]=0.
  - JALR: funct3=000.
  - BRANCH: funct3 not 010/011.
  - LOAD: funct3 in {000,001,010,100,101}.
  - STORE: funct3 in {000,001,010}.
  - OP-IMM shifts (funct3 001/101): imm[31:5]=0; funct7_b5 only allowed with funct3 101. Word = {0,b5,00000,shamt,...}.
  - OP: funct7_b5 only allowed with funct3 000/101.
  - Class 9-15 illegal.
- Illegal command:
  - Accepted under the same ready rule.
  - Produces no write; address and count unchanged.
  - o_illegal=1 for one cycle; o_err set.
- i_restart:
  - Drops any pending write (o_wr_valid=0); o_cmd_ready=0 that cycle.
  - Address=BASE_ADDR, o_count=0, o_err=0.
  - Has priority over completion and acceptance in the same cycle.
- Reset mid-transfer: pending write discarded immediately and asynchronously.

Test Plan:
- AUIPC rd=5 imm=32'h12345000, i_wr_ready=1 -> one cycle later o_wr_valid=1, o_wr_addr=0, o_wr_data=32'h12345297.
- Back-to-back, i_wr_ready=1:
  - OP-IMM ADDI rd=1 rs1=0 imm=1 -> 32'h00100093 @0.
  - BRANCH f3=000 rs1=1 rs2=2 imm=8 -> 32'h00208463 @4.
  - JAL rd=1 imm=32'h800 -> 32'h001000EF @8.
  - o_count=3.
- Backpressure: i_wr_ready=0 for 3 cycles with i_cmd_valid=1 -> o_cmd_ready=0, o_wr_data/o_wr_addr stable; first accepted on release, no command lost or duplicated.
- Illegal: AUIPC imm=32'h12345001, then BRANCH imm=7, then class 12 -> three o_illegal pulses, no o_wr_valid, o_wr_addr unchanged, o_err=1 sticky.
- Restart/wrap:
  - ADDR_W=4, write 5 words -> addresses 0,4,8,C,0.
  - i_restart with pending write -> o_wr_valid=0, addr=0, o_count=0, o_err=0.
- Async reset asserted while o_wr_valid=1 && i_wr_ready=0 -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/rv32i_inst_encoder_if.sv
// Command and IMEM-write bundle for rv32i_inst_encoder.
// The slave modport is the encoder; the master modport is whoever issues commands and owns IMEM.
interface rv32i_inst_encoder_if #(
  parameter int ADDR_W = 32
);
  // command channel
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [3:0]        i_cmd_class;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [2:0]        i_funct3;
  logic              i_funct7_b5;
  logic [31:0]       i_imm;

  // IMEM write channel
  logic              o_wr_valid;
  logic              i_wr_ready;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;

  // status
  logic              o_illegal;
  logic              o_err;
  logic [15:0]       o_count;

  modport slave (
    input  i_cmd_valid, i_cmd_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7_b5, i_imm,
    input  i_wr_ready,
    output o_cmd_ready, o_wr_valid, o_wr_addr, o_wr_data, o_illegal, o_err, o_count
  );

  modport master (
    output i_cmd_valid, i_cmd_class, i_rd, i_rs1, i_rs2, i_funct3, i_funct7_b5, i_imm,
    output i_wr_ready,
    input  o_cmd_ready, o_wr_valid, o_wr_addr, o_wr_data, o_illegal, o_err, o_count
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Packs field-level RV32I commands into instruction words and streams them as sequential IMEM writes.
// A single output register holds the pending write; illegal commands are consumed, flagged and dropped.
module rv32i_inst_encoder #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_restart,
  rv32i_inst_encoder_if.slave  bus
);

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_OPIMM  = 4'd7,
    CLS_OP     = 4'd8
  } cmd_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // ---------------------------------------------------------------------------
  // Field aliases and immediate range checks
  // ---------------------------------------------------------------------------
  cmd_class_e  cmd_class;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        b5;

  assign cmd_class = cmd_class_e'(bus.i_cmd_class);
  assign imm       = bus.i_imm;
  assign rd        = bus.i_rd;
  assign rs1       = bus.i_rs1;
  assign rs2       = bus.i_rs2;
  assign f3        = bus.i_funct3;
  assign b5        = bus.i_funct7_b5;

  // A value fits N signed bits when every bit above N-1 copies bit N-1.
  logic fits12, fits13, fits21, is_shift;
  assign fits12   = (imm[31:11] == {21{imm[11]}});
  assign fits13   = (imm[31:12] == {20{imm[12]}});
  assign fits21   = (imm[31:20] == {12{imm[20]}});
  assign is_shift = (f3[1:0] == 2'b01);

  // ---------------------------------------------------------------------------
  // Encoder: instruction word and legality for the presented command
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path through the case infers a latch.
    enc_word  = '0;
    enc_legal = 1'b0;
    case (cmd_class)
      CLS_LUI: begin
        enc_word  = {imm[31:12], rd, OPC_LUI};
        enc_legal = (imm[11:0] == 12'h000);
      end
      CLS_AUIPC: begin
        enc_word  = {imm[31:12], rd, OPC_AUIPC};
        enc_legal = (imm[11:0] == 12'h000);
      end
      CLS_JAL: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        enc_legal = fits21 && !imm[0];
      end
      CLS_JALR: begin
        enc_word  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        enc_legal = fits12 && (f3 == 3'b000);
      end
      CLS_BRANCH: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
        enc_legal = fits13 && !imm[0] && (f3[2:1] != 2'b01);
      end
      CLS_LOAD: begin
        enc_word  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
        enc_legal = fits12 && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      CLS_STORE: begin
        enc_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
        enc_legal = fits12 && !f3[2] && (f3 != 3'b011);
      end
      CLS_OPIMM: begin
        if (is_shift) begin
          // Shifts carry a 5-bit shamt; bit 30 selects SRAI and is meaningless for SLLI.
          enc_word  = {1'b0, b5, 5'b00000, imm[4:0], rs1, f3, rd, OPC_OPIMM};
          enc_legal = (imm[31:5] == 27'd0) && (!b5 || (f3 == 3'b101));
        end else begin
          enc_word  = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
          enc_legal = fits12 && !b5;
        end
      end
      CLS_OP: begin
        enc_word  = {1'b0, b5, 5'b00000, rs2, rs1, f3, rd, OPC_OP};
        enc_legal = !b5 || (f3 == 3'b000) || (f3 == 3'b101);
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]       wr_data_q,  wr_data_d;
  logic              illegal_q,  illegal_d;
  logic              err_q,      err_d;
  logic [15:0]       count_q,    count_d;

  logic cmd_ready, accept, wr_done;

  // The single output slot frees up in the same cycle its write completes; restart blocks intake.
  assign cmd_ready = (!wr_valid_q || bus.i_wr_ready) && !i_restart;
  assign accept    = bus.i_cmd_valid && cmd_ready;
  assign wr_done   = wr_valid_q && bus.i_wr_ready;

  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    illegal_d  = 1'b0;
    err_d      = err_q;
    count_d    = count_q;

    if (i_restart) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = BASE;
      err_d      = 1'b0;
      count_d    = '0;
    end else begin
      if (wr_done) begin
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q + ADDR_W'(4);
        count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      end
      if (accept) begin
        if (enc_legal) begin
          wr_valid_d = 1'b1;
          wr_data_d  = enc_word;
        end else begin
          illegal_d = 1'b1;
          err_d     = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= '0;
      illegal_q  <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_wr_valid  = wr_valid_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_err       = err_q;
  assign bus.o_count     = count_q;

  // A stalled write must not move until IMEM takes it or a restart drops it.
  a_stall_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (wr_valid_q && !bus.i_wr_ready && !i_restart) |=>
      (wr_valid_q && $stable(wr_data_q) && $stable(wr_addr_q)));

  a_illegal_sets_err: assert property (@(posedge i_clk) disable iff (i_reset)
    illegal_q |-> err_q);

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Self-checking bench for rv32i_inst_encoder: a transaction-level reference model checked every cycle,
// plus directed sequences with hand-computed words, and a narrow-address instance to exercise wrap.
module tb_rv32i_inst_encoder;

  logic clk = 1'b0;
  logic rst;
  logic restart;

  always #5 clk = ~clk;

  rv32i_inst_encoder_if #(.ADDR_W(32)) bus ();
  rv32i_inst_encoder_if #(.ADDR_W(4))  bus_w ();

  // The narrow instance sees exactly the same command and write-ready stimulus.
  assign bus_w.i_cmd_valid = bus.i_cmd_valid;
  assign bus_w.i_cmd_class = bus.i_cmd_class;
  assign bus_w.i_rd        = bus.i_rd;
  assign bus_w.i_rs1       = bus.i_rs1;
  assign bus_w.i_rs2       = bus.i_rs2;
  assign bus_w.i_funct3    = bus.i_funct3;
  assign bus_w.i_funct7_b5 = bus.i_funct7_b5;
  assign bus_w.i_imm       = bus.i_imm;
  assign bus_w.i_wr_ready  = bus.i_wr_ready;

  rv32i_inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_restart (restart),
    .bus       (bus)
  );

  rv32i_inst_encoder #(.ADDR_W(4), .BASE_ADDR(32'h0)) dut_w (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_restart (restart),
    .bus       (bus_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference encoder, written from the instruction formats with plain arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic void ref_encode(input int cls, input int rd, input int rs1, input int rs2,
                                     input int f3, input bit b5, input logic [31:0] imm,
                                     output bit legal, output logic [31:0] word);
    int s;
    logic [31:0] r_d, r_s1, r_s2, f_3, i_type;
    s      = $signed(imm);
    r_d    = 32'(rd) << 7;
    r_s1   = 32'(rs1) << 15;
    r_s2   = 32'(rs2) << 20;
    f_3    = 32'(f3) << 12;
    i_type = (fld(imm, 11, 0) << 20) | r_s1 | f_3 | r_d;
    legal  = 1'b0;
    word   = 32'd0;
    case (cls)
      0: begin legal = (imm & 32'hFFF) == 0; word = (imm & 32'hFFFF_F000) | r_d | 32'h37; end
      1: begin legal = (imm & 32'hFFF) == 0; word = (imm & 32'hFFFF_F000) | r_d | 32'h17; end
      2: begin
        legal = (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
        word  = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
              | (fld(imm, 19, 12) << 12) | r_d | 32'h6F;
      end
      3: begin
        legal = (s >= -2048) && (s <= 2047) && (f3 == 0);
        word  = (fld(imm, 11, 0) << 20) | r_s1 | r_d | 32'h67;
      end
      4: begin
        legal = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0) && (f3 != 2) && (f3 != 3);
        word  = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | r_s2 | r_s1 | f_3
              | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
      end
      5: begin
        legal = (s >= -2048) && (s <= 2047) && (f3 inside {0, 1, 2, 4, 5});
        word  = i_type | 32'h03;
      end
      6: begin
        legal = (s >= -2048) && (s <= 2047) && (f3 <= 2);
        word  = (fld(imm, 11, 5) << 25) | r_s2 | r_s1 | f_3 | (fld(imm, 4, 0) << 7) | 32'h23;
      end
      7: begin
        if (f3 == 1 || f3 == 5) begin
          legal = (imm <= 32'd31) && (!b5 || f3 == 5);
          word  = (32'(b5) << 30) | (fld(imm, 4, 0) << 20) | r_s1 | f_3 | r_d | 32'h13;
        end else begin
          legal = (s >= -2048) && (s <= 2047) && !b5;
          word  = i_type | 32'h13;
        end
      end
      8: begin
        legal = !b5 || (f3 == 0) || (f3 == 5);
        word  = (32'(b5) << 30) | r_s2 | r_s1 | f_3 | r_d | 32'h33;
      end
      default: begin legal = 1'b0; word = 32'd0; end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction model: one pending write slot, byte address, sticky error, counter
  // ---------------------------------------------------------------------------
  bit          m_valid   = 1'b0;
  logic [31:0] m_addr    = 32'd0;
  logic [31:0] m_data    = 32'd0;
  bit          m_illegal = 1'b0;
  bit          m_err     = 1'b0;
  int          m_count   = 0;

  task automatic model_step();
    bit legal, slot_free, taken, written;
    logic [31:0] w;
    if (rst) begin
      m_valid = 0; m_addr = 0; m_data = 0; m_illegal = 0; m_err = 0; m_count = 0;
      return;
    end
    m_illegal = 0;
    if (restart) begin
      m_valid = 0; m_addr = 0; m_count = 0; m_err = 0;
      return;
    end
    slot_free = !m_valid || bus.i_wr_ready;
    taken     = bus.i_cmd_valid && slot_free;
    written   = m_valid && bus.i_wr_ready;
    if (written) begin
      m_valid = 0;
      m_addr  = m_addr + 4;
      if (m_count < 65535) m_count++;
    end
    if (taken) begin
      ref_encode(int'(bus.i_cmd_class), int'(bus.i_rd), int'(bus.i_rs1), int'(bus.i_rs2),
                 int'(bus.i_funct3), bus.i_funct7_b5, bus.i_imm, legal, w);
      if (legal) begin
        m_valid = 1;
        m_data  = w;
      end else begin
        m_illegal = 1;
        m_err     = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    bit exp_ready;
    exp_ready = (!m_valid || bus.i_wr_ready) && !restart;
    check("cmd_ready", 32'(bus.o_cmd_ready), 32'(exp_ready));
    check("wr_valid",  32'(bus.o_wr_valid),  32'(m_valid));
    check("wr_addr",   bus.o_wr_addr,        m_addr);
    check("illegal",   32'(bus.o_illegal),   32'(m_illegal));
    check("err",       32'(bus.o_err),       32'(m_err));
    check("count",     32'(bus.o_count),     32'(m_count));
    check("w4_valid",  32'(bus_w.o_wr_valid), 32'(m_valid));
    check("w4_addr",   32'(bus_w.o_wr_addr),  m_addr & 32'hF);
    check("w4_count",  32'(bus_w.o_count),    32'(m_count));
    if (m_valid) begin
      check("wr_data",    bus.o_wr_data,   m_data);
      check("w4_wr_data", bus_w.o_wr_data, m_data);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_outputs();
  end

  // ---------------------------------------------------------------------------
  // Drivers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive_cmd(input int cls, input int rd, input int rs1, input int rs2,
                           input int f3, input bit b5, input logic [31:0] imm);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_class = 4'(cls);
    bus.i_rd        = 5'(rd);
    bus.i_rs1       = 5'(rs1);
    bus.i_rs2       = 5'(rs2);
    bus.i_funct3    = 3'(f3);
    bus.i_funct7_b5 = b5;
    bus.i_imm       = imm;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = bus.o_cmd_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send(input int cls, input int rd, input int rs1, input int rs2,
                      input int f3, input bit b5, input logic [31:0] imm);
    drive_cmd(cls, rd, rs1, rs2, f3, b5, imm);
    wait_accept();
  endtask

  task automatic idle();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    #1;
    check("ready_during_restart", 32'(bus.o_cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      2:       return $urandom & 32'hFFFF_F000;
      3:       return 32'($urandom_range(0, 40));
      4:       return 32'(int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20)) & 32'hFFFF_FFFE;
      default: return 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Directed and random sequences
  // ---------------------------------------------------------------------------
  initial begin
    bit          lg;
    logic [31:0] w, wa, wb;

    rst     = 1'b1;
    restart = 1'b0;
    bus.i_wr_ready = 1'b1;
    drive_cmd(0, 0, 0, 0, 0, 1'b0, 32'd0);
    idle();

    // Hand-computed words that pin the reference encoder itself.
    ref_encode(1, 5, 0, 0, 0, 1'b0, 32'h1234_5000, lg, w);
    check("model_auipc", w, 32'h1234_5297);
    check("model_auipc_legal", 32'(lg), 32'd1);
    ref_encode(7, 1, 2, 0, 5, 1'b1, 32'd3, lg, w);
    check("model_srai", w, 32'h4031_5093);
    ref_encode(6, 0, 1, 2, 2, 1'b0, 32'hFFFF_FFFC, lg, w);
    check("model_sw", w, 32'hFE20_AE23);
    ref_encode(4, 0, 1, 2, 0, 1'b0, 32'd7, lg, w);
    check("model_branch_odd_illegal", 32'(lg), 32'd0);

    repeat (2) step();
    check("rst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
    check("rst_wr_addr",  bus.o_wr_addr,       32'd0);
    check("rst_wr_data",  bus.o_wr_data,       32'd0);
    check("rst_illegal",  32'(bus.o_illegal),  32'd0);
    check("rst_err",      32'(bus.o_err),      32'd0);
    check("rst_count",    32'(bus.o_count),    32'd0);
    rst = 1'b0;
    step();

    // First-transaction latency.
    send(1, 5, 0, 0, 0, 1'b0, 32'h1234_5000);
    check("auipc_valid", 32'(bus.o_wr_valid), 32'd1);
    check("auipc_addr",  bus.o_wr_addr,       32'd0);
    check("auipc_data",  bus.o_wr_data,       32'h1234_5297);
    idle();
    pulse_restart();
    check("restart1_addr", bus.o_wr_addr, 32'd0);

    // Back-to-back stream.
    send(7, 1, 0, 0, 0, 1'b0, 32'd1);
    check("b2b_addi", bus.o_wr_data, 32'h0010_0093);
    check("b2b_addi_addr", bus.o_wr_addr, 32'd0);
    send(4, 0, 1, 2, 0, 1'b0, 32'd8);
    check("b2b_beq", bus.o_wr_data, 32'h0020_8463);
    check("b2b_beq_addr", bus.o_wr_addr, 32'd4);
    send(2, 1, 0, 0, 0, 1'b0, 32'h800);
    check("b2b_jal", bus.o_wr_data, 32'h0010_00EF);
    check("b2b_jal_addr", bus.o_wr_addr, 32'd8);
    idle();
    step();
    check("b2b_count", 32'(bus.o_count), 32'd3);
    check("b2b_drained", 32'(bus.o_wr_valid), 32'd0);

    // Backpressure: second command must wait, first must hold still.
    bus.i_wr_ready = 1'b0;
    ref_encode(7, 3, 0, 0, 0, 1'b0, 32'd5, lg, wa);
    ref_encode(8, 4, 1, 2, 0, 1'b0, 32'd0, lg, wb);
    send(7, 3, 0, 0, 0, 1'b0, 32'd5);
    check("bp_first_data", bus.o_wr_data, wa);
    drive_cmd(8, 4, 1, 2, 0, 1'b0, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 32'(bus.o_cmd_ready), 32'd0);
      step();
      check("bp_data_stable", bus.o_wr_data, wa);
      check("bp_addr_stable", bus.o_wr_addr, 32'd12);
    end
    bus.i_wr_ready = 1'b1;
    step();
    check("bp_second_data", bus.o_wr_data, wb);
    check("bp_second_addr", bus.o_wr_addr, 32'd16);
    idle();
    step();
    check("bp_count", 32'(bus.o_count), 32'd5);
    check("bp_addr_after", bus.o_wr_addr, 32'd20);

    // Illegal commands: three pulses, no writes.
    send(1, 5, 0, 0, 0, 1'b0, 32'h1234_5001);
    check("ill_auipc_pulse", 32'(bus.o_illegal), 32'd1);
    check("ill_auipc_novalid", 32'(bus.o_wr_valid), 32'd0);
    check("ill_auipc_err", 32'(bus.o_err), 32'd1);
    send(4, 0, 1, 2, 0, 1'b0, 32'd7);
    check("ill_branch_pulse", 32'(bus.o_illegal), 32'd1);
    send(12, 1, 1, 1, 0, 1'b0, 32'd0);
    check("ill_class_pulse", 32'(bus.o_illegal), 32'd1);
    idle();
    step();
    check("ill_pulse_end", 32'(bus.o_illegal), 32'd0);
    check("ill_err_sticky", 32'(bus.o_err), 32'd1);
    check("ill_addr_same", bus.o_wr_addr, 32'd20);
    check("ill_count_same", 32'(bus.o_count), 32'd5);

    // Address wrap on the 4-bit instance.
    pulse_restart();
    for (int i = 0; i < 5; i++) begin
      send(7, i + 1, 0, 0, 0, 1'b0, 32'(i));
      check("wrap_w4_addr", 32'(bus_w.o_wr_addr), 32'((i * 4) % 16));
      check("wrap_addr", bus.o_wr_addr, 32'(i * 4));
    end
    idle();
    step();

    // Restart with a pending write and a set error flag.
    send(9, 0, 0, 0, 0, 1'b0, 32'd0);
    bus.i_wr_ready = 1'b0;
    send(0, 7, 0, 0, 0, 1'b0, 32'hABCD_E000);
    check("pend_valid", 32'(bus.o_wr_valid), 32'd1);
    check("pend_err", 32'(bus.o_err), 32'd1);
    idle();
    pulse_restart();
    check("rs_valid", 32'(bus.o_wr_valid), 32'd0);
    check("rs_addr", bus.o_wr_addr, 32'd0);
    check("rs_w4_addr", 32'(bus_w.o_wr_addr), 32'd0);
    check("rs_count", 32'(bus.o_count), 32'd0);
    check("rs_err", 32'(bus.o_err), 32'd0);
    bus.i_wr_ready = 1'b1;

    // Random traffic against the model.
    repeat (3000) begin
      bus.i_cmd_valid = ($urandom_range(0, 99) < 70);
      bus.i_cmd_class = 4'($urandom_range(0, 99) < 90 ? $urandom_range(0, 8) : $urandom_range(9, 15));
      bus.i_rd        = 5'($urandom);
      bus.i_rs1       = 5'($urandom);
      bus.i_rs2       = 5'($urandom);
      bus.i_funct3    = 3'($urandom);
      bus.i_funct7_b5 = ($urandom_range(0, 3) == 0);
      bus.i_imm       = rand_imm();
      bus.i_wr_ready  = ($urandom_range(0, 99) < 70);
      restart         = ($urandom_range(0, 99) < 2);
      step();
    end
    restart = 1'b0;
    idle();
    bus.i_wr_ready = 1'b1;
    step();

    // Asynchronous reset while a write is stalled.
    bus.i_wr_ready = 1'b0;
    send(0, 2, 0, 0, 0, 1'b0, 32'h0000_1000);
    check("ar_pending", 32'(bus.o_wr_valid), 32'd1);
    idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_wr_valid", 32'(bus.o_wr_valid), 32'd0);
    check("ar_wr_addr",  bus.o_wr_addr,       32'd0);
    check("ar_wr_data",  bus.o_wr_data,       32'd0);
    check("ar_count",    32'(bus.o_count),    32'd0);
    check("ar_err",      32'(bus.o_err),      32'd0);
    check("ar_illegal",  32'(bus.o_illegal),  32'd0);
    step();
    rst = 1'b0;
    bus.i_wr_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
